icache_2way_axi: RTL and testbench
==================================

Name: icache_2way_axi

Overview:
- Parametrised 2-way set-associative instruction cache between the fetch stage and the AXI4 read port.
- Returns a FETCH_W-instruction pack starting at the requested PC.
- On a miss, refills a whole line with one INCR burst.
- Adds a pipelined valid/ready request port, per-set LRU replacement, line-boundary masking and refill error reporting.

Parameters:
- SETS, 256, number of sets (power of 2); INDEX_W = log2(SETS).
- LINE_WORDS, 8, 32-bit words per line (power of 2, 2..16); OFF_W = log2(LINE_WORDS).
- FETCH_W, 4, instructions per fetch pack (1 <= FETCH_W <= LINE_WORDS).
- TAG_W is derived as 32 - INDEX_W - OFF_W - 2.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  cache can accept a request.
- req_pc  in  32  fetch PC; bits [1:0] are ignored.
- resp_valid  out  1  one-cycle response strobe; the consumer cannot stall it.
- resp_pc  out  32  PC of the response.
- resp_pack  out  32*FETCH_W  instructions; word 0 is at [31:0].
- resp_mask  out  FETCH_W  bit i=1 when word i lies inside the line.
- resp_err  out  1  the refill returned a non-OKAY RRESP.
- araddr  out  32  line-aligned refill address.
- arlen  out  8  constant LINE_WORDS-1.
- arsize  out  3  constant 3'b010.
- arburst  out  2  constant 2'b01 (INCR).
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- rdata  in  32  read data.
- rresp  in  2  read response.
- rlast  in  1  last beat of the burst.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.

Behaviour:
- Storage is flop arrays per way: valid[SETS], tag[SETS][TAG_W], data[SETS][LINE_WORDS*32]. There is one lru[SETS] bit, where 1 means way1 is least recently used.
- Reset (asynchronous): state=IDLE; all valid and lru bits cleared; all outputs 0; req_ready=1.
- Reset mid-refill abandons the burst; this is acceptable only under a system-wide reset.
- States:
  - IDLE: req_ready=1. A request is accepted on req_valid&req_ready, the PC is latched, and the state goes to LOOKUP.
  - LOOKUP: tag compare on the latched PC.
    - Hit: resp_valid=1 in this cycle, so hit latency is 1 cycle after acceptance. lru[idx] points to the way not hit.
    - Hit with a new request presented: req_ready=1 and the new request is accepted in the same cycle (back-to-back, 1 per cycle).
    - Hit with no request: go to IDLE.
    - Miss: req_ready=0, go to MISS.
  - MISS: arvalid=1 with araddr = {tag, idx, OFF_W+2 zero bits}. The address is held stable until arready, then go to REFILL.
  - REFILL: rready=1. Beat k is written to line buffer word k. Any non-OKAY rresp sets a sticky err flag.
    - On rvalid&rlast with err clear: install the buffer into way lru[idx], set valid and tag, and go to LOOKUP (replay). The replay hits, so miss latency = AR handshake + beats + 1.
    - On rvalid&rlast with err set: do not install; resp_valid=1 with resp_err=1, resp_mask=0, resp_pack=0, then go to IDLE.
- Fetch pack: word i = line word (pc[OFF_W+1:2]+i).
  - resp_mask[i] = (pc word offset + i < LINE_WORDS).
  - Masked words are driven 0; there is no wrap into the next line.
- If both ways hit (illegal state), way0 wins.
- The victim is always the LRU way; an invalid way is not preferred over the LRU way.
- Beats arriving after rlast are not possible (single outstanding burst).

Optional Feature:
- Macro: ICACHE_FLUSH_EN.
- Enabled:
  - Adds input flush (1 bit) and state FLUSH.
  - flush is sampled only in IDLE and takes priority over req_valid. The cache then spends SETS cycles clearing valid/lru bits set by set, with req_ready=0.
  - flush asserted in any other state is held by the requester until IDLE.
- Disabled: no flush port and no FLUSH state. Valid bits clear only on reset.

Decomposition:
- Package icache_pkg:
  - State enum (IDLE, LOOKUP, MISS, REFILL, FLUSH).
  - AXI constants: BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY=2'b00.
  - Functions for index/tag/offset extraction.
- Sub-module icache_way holds the valid/tag/data arrays of one way, with compare and install ports. It is instantiated twice; LRU and the FSM stay in the top.

Test Plan:
- Cold miss (defaults): req_pc=0x0000_1000 -> arvalid with araddr=0x1000, arlen=7; 8 beats 0xA0..0xA7 with rlast on beat 8 -> resp_valid with pack {A3,A2,A1,A0}, mask=4'b1111.
- Line-edge mask: after the first scenario, req_pc=0x1018 -> hit one cycle after acceptance; pack words 0..1 = A6, A7; mask=4'b0011; words 2..3 = 0.
- Back-to-back hits: req_valid held for PCs 0x1000, 0x1004, 0x1008 -> three consecutive resp_valid cycles, no arvalid.
- LRU eviction: fill tags T0 then T1 in set 0x80, access T0, then miss on T2 -> T1's way replaced; a subsequent T0 access hits, T1 misses.
- Refill error: rresp=2'b10 on beat 3 -> resp_valid with resp_err=1, mask=0; a repeat of the same PC misses again.
- Flush (ICACHE_FLUSH_EN only): flush in IDLE -> req_ready low for exactly SETS cycles; a previously hitting PC then misses.

Source files
------------

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared types, AXI constants and address-field helpers for the 2-way
// instruction cache (icache_2way_axi / icache_way).
// Optional feature macro used by the top: ICACHE_FLUSH_EN.
// -----------------------------------------------------------------------------
package icache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOOKUP,
      MISS,
      REFILL,
      FLUSH
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Word offset inside the line (byte bits [1:0] dropped).
   function automatic logic [31:0] f_offset(input logic [31:0] pc,
                                            input int unsigned off_w);
      return (pc >> 2) & ((32'd1 << off_w) - 32'd1);
   endfunction

   function automatic logic [31:0] f_index(input logic [31:0] pc,
                                           input int unsigned off_w,
                                           input int unsigned index_w);
      return (pc >> (off_w + 2)) & ((32'd1 << index_w) - 32'd1);
   endfunction

   function automatic logic [31:0] f_tag(input logic [31:0] pc,
                                         input int unsigned off_w,
                                         input int unsigned index_w);
      return pc >> (off_w + index_w + 2);
   endfunction

endpackage

// File: rtl/icache_way.sv
// -----------------------------------------------------------------------------
// icache_way
// One way of the instruction cache: valid/tag/data flop arrays with a
// combinational compare port, a whole-line install port and a per-set
// invalidate port.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (valid bits)
//   i_rd_idx, i_rd_tag    lookup set and tag
//   o_hit, o_line         tag match on a valid entry, line contents of the set
//   i_wr_en/idx/tag/line  install a full line and mark it valid
//   i_inv_en, i_inv_idx   clear the valid bit of one set
// -----------------------------------------------------------------------------
module icache_way
   import icache_pkg::*;
#(
   parameter int unsigned SETS       = 256,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned INDEX_W    = 8,
   parameter int unsigned TAG_W      = 19
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [INDEX_W-1:0]         i_rd_idx,
   input  logic [TAG_W-1:0]           i_rd_tag,
   output logic                       o_hit,
   output logic [LINE_WORDS*32-1:0]   o_line,
   input  logic                       i_wr_en,
   input  logic [INDEX_W-1:0]         i_wr_idx,
   input  logic [TAG_W-1:0]           i_wr_tag,
   input  logic [LINE_WORDS*32-1:0]   i_wr_line,
   input  logic                       i_inv_en,
   input  logic [INDEX_W-1:0]         i_inv_idx
);

   logic [SETS-1:0]                 r_valid;
   logic [TAG_W-1:0]                r_tag  [SETS];
   logic [LINE_WORDS*32-1:0]        r_data [SETS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
      end else begin
         if (i_inv_en) r_valid[i_inv_idx] <= 1'b0;
         if (i_wr_en)  r_valid[i_wr_idx]  <= 1'b1;
      end
   end

   // Tag and data contents are qualified by r_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_tag[i_wr_idx]  <= i_wr_tag;
         r_data[i_wr_idx] <= i_wr_line;
      end
   end

   assign o_hit  = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
   assign o_line = r_data[i_rd_idx];

endmodule

// File: rtl/icache_2way_axi.sv
// -----------------------------------------------------------------------------
// icache_2way_axi
// 2-way set-associative instruction cache with per-set LRU replacement and
// whole-line AXI4 INCR refill. Returns a FETCH_W-word pack starting at the
// requested PC; words past the end of the line are masked and driven 0.
// Ports:
//   clk, resetn                 clock, asynchronous active-low reset
//   flush                       (ICACHE_FLUSH_EN only) invalidate all sets
//   req_valid/req_ready/req_pc  fetch request handshake
//   resp_valid/pc/pack/mask/err one-cycle response strobe and payload
//   ar*, r*                     AXI4 read address / read data channels
// Optional feature macro: ICACHE_FLUSH_EN (adds flush input and FLUSH state).
// -----------------------------------------------------------------------------
module icache_2way_axi
   import icache_pkg::*;
#(
   parameter int unsigned SETS       = 256,
   parameter int unsigned LINE_WORDS = 8,
   parameter int unsigned FETCH_W    = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
`ifdef ICACHE_FLUSH_EN
   input  logic                   flush,
`endif
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [31:0]            req_pc,
   output logic                   resp_valid,
   output logic [31:0]            resp_pc,
   output logic [32*FETCH_W-1:0]  resp_pack,
   output logic [FETCH_W-1:0]     resp_mask,
   output logic                   resp_err,
   output logic [31:0]            araddr,
   output logic [7:0]             arlen,
   output logic [2:0]             arsize,
   output logic [1:0]             arburst,
   output logic                   arvalid,
   input  logic                   arready,
   input  logic [31:0]            rdata,
   input  logic [1:0]             rresp,
   input  logic                   rlast,
   input  logic                   rvalid,
   output logic                   rready
);

   localparam int unsigned INDEX_W = $clog2(SETS);
   localparam int unsigned OFF_W   = $clog2(LINE_WORDS);
   localparam int unsigned TAG_W   = 32 - INDEX_W - OFF_W - 2;

   state_t                         r_state;
   logic [31:0]                    r_pc;
   logic [SETS-1:0]                r_lru;
   logic [LINE_WORDS-1:0][31:0]    r_buf;
   logic [OFF_W-1:0]               r_beat;
   logic                           r_err;
   logic                           r_err_pulse;

   logic [INDEX_W-1:0]             w_idx;
   logic [TAG_W-1:0]               w_tag;
   logic [OFF_W-1:0]               w_off;
   logic                           w_hit0;
   logic                           w_hit1;
   logic                           w_hit;
   logic                           w_lookup_hit;
   logic [LINE_WORDS-1:0][31:0]    w_line0;
   logic [LINE_WORDS-1:0][31:0]    w_line1;
   logic [LINE_WORDS-1:0][31:0]    w_line;
   logic [LINE_WORDS-1:0][31:0]    w_fill_line;
   logic                           w_err_now;
   logic                           w_install;
   logic                           w_inv_en;
   logic [INDEX_W-1:0]             w_inv_idx;
   logic                           w_idle_ready;

`ifdef ICACHE_FLUSH_EN
   logic [INDEX_W-1:0]             r_flush_idx;
`endif

   assign w_idx = INDEX_W'(f_index(r_pc, OFF_W, INDEX_W));
   assign w_tag = TAG_W'(f_tag(r_pc, OFF_W, INDEX_W));
   assign w_off = OFF_W'(f_offset(r_pc, OFF_W));

   assign arlen   = 8'(LINE_WORDS - 1);
   assign arsize  = SIZE_4B;
   assign arburst = BURST_INCR;

   icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) u_way0 (
      .clk       (clk),
      .rst_n     (resetn),
      .i_rd_idx  (w_idx),
      .i_rd_tag  (w_tag),
      .o_hit     (w_hit0),
      .o_line    (w_line0),
      .i_wr_en   (w_install && !r_lru[w_idx]),
      .i_wr_idx  (w_idx),
      .i_wr_tag  (w_tag),
      .i_wr_line (w_fill_line),
      .i_inv_en  (w_inv_en),
      .i_inv_idx (w_inv_idx)
   );

   icache_way #(
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W)
   ) u_way1 (
      .clk       (clk),
      .rst_n     (resetn),
      .i_rd_idx  (w_idx),
      .i_rd_tag  (w_tag),
      .o_hit     (w_hit1),
      .o_line    (w_line1),
      .i_wr_en   (w_install && r_lru[w_idx]),
      .i_wr_idx  (w_idx),
      .i_wr_tag  (w_tag),
      .i_wr_line (w_fill_line),
      .i_inv_en  (w_inv_en),
      .i_inv_idx (w_inv_idx)
   );

   // Way0 wins if both ways ever match.
   assign w_hit        = w_hit0 || w_hit1;
   assign w_line       = w_hit0 ? w_line0 : w_line1;
   assign w_lookup_hit = (r_state == LOOKUP) && w_hit;

   // The final beat is merged here so the line installs on the rlast cycle.
   always_comb begin
      w_fill_line         = r_buf;
      w_fill_line[r_beat] = rdata;
   end

   assign w_err_now = r_err || (rresp != RESP_OKAY);
   assign w_install = (r_state == REFILL) && rvalid && rlast && !w_err_now;

`ifdef ICACHE_FLUSH_EN
   // The IDLE cycle that samples flush already clears set 0, so the whole
   // sweep (IDLE + FLUSH) keeps req_ready low for exactly SETS cycles.
   assign w_idle_ready = !flush;
   assign w_inv_en     = ((r_state == IDLE) && flush) || (r_state == FLUSH);
   assign w_inv_idx    = (r_state == FLUSH) ? r_flush_idx : '0;
`else
   assign w_idle_ready = 1'b1;
   assign w_inv_en     = 1'b0;
   assign w_inv_idx    = '0;
`endif

   assign req_ready = ((r_state == IDLE) && w_idle_ready) || w_lookup_hit;

   always_comb begin
      resp_valid = w_lookup_hit || r_err_pulse;
      resp_err   = r_err_pulse;
      resp_pc    = (w_lookup_hit || r_err_pulse) ? r_pc : '0;
      resp_pack  = '0;
      resp_mask  = '0;
      if (w_lookup_hit) begin
         for (int unsigned i = 0; i < FETCH_W; i++) begin
            if (32'(w_off) + i < LINE_WORDS) begin
               resp_mask[i]          = 1'b1;
               resp_pack[i*32 +: 32] = w_line[OFF_W'(32'(w_off) + i)];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= IDLE;
         r_pc        <= '0;
         r_lru       <= '0;
         r_buf       <= '0;
         r_beat      <= '0;
         r_err       <= 1'b0;
         r_err_pulse <= 1'b0;
         arvalid     <= 1'b0;
         araddr      <= '0;
         rready      <= 1'b0;
`ifdef ICACHE_FLUSH_EN
         r_flush_idx <= '0;
`endif
      end else begin
         r_err_pulse <= 1'b0;
         case (r_state)
            IDLE: begin
`ifdef ICACHE_FLUSH_EN
               if (flush) begin
                  r_lru[0]    <= 1'b0;
                  r_flush_idx <= INDEX_W'(1);
                  r_state     <= FLUSH;
               end else
`endif
               if (req_valid) begin
                  r_pc    <= req_pc;
                  r_state <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (w_hit) begin
                  // Mark the way that was not hit as least recently used.
                  r_lru[w_idx] <= w_hit0;
                  if (req_valid) r_pc    <= req_pc;
                  else           r_state <= IDLE;
               end else begin
                  arvalid <= 1'b1;
                  araddr  <= {w_tag, w_idx, {(OFF_W + 2){1'b0}}};
                  r_state <= MISS;
               end
            end
            MISS: begin
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  r_beat  <= '0;
                  r_err   <= 1'b0;
                  r_state <= REFILL;
               end
            end
            REFILL: begin
               if (rvalid) begin
                  r_buf[r_beat] <= rdata;
                  r_beat        <= r_beat + 1'b1;
                  if (rresp != RESP_OKAY) r_err <= 1'b1;
                  if (rlast) begin
                     rready <= 1'b0;
                     if (w_err_now) begin
                        r_err_pulse <= 1'b1;
                        r_state     <= IDLE;
                     end else begin
                        r_state <= LOOKUP;
                     end
                  end
               end
            end
`ifdef ICACHE_FLUSH_EN
            FLUSH: begin
               r_lru[r_flush_idx] <= 1'b0;
               r_flush_idx        <= r_flush_idx + 1'b1;
               if (r_flush_idx == INDEX_W'(SETS - 1)) r_state <= IDLE;
            end
`endif
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_2way_axi.sv
// -----------------------------------------------------------------------------
// tb_icache_2way_axi
// Directed scoreboard bench for icache_2way_axi with default parameters
// (SETS=256, LINE_WORDS=8, FETCH_W=4). Expected responses and expected AR
// addresses are queued by the stimulus; a response monitor and an AXI slave
// model pop and compare them independently.
// Slave data: line 0x1000 returns 0xA0+k on beat k; any other line L returns
// 0xC000_0000 + L + 4k.
// -----------------------------------------------------------------------------
module tb_icache_2way_axi;

   typedef struct {
      logic [31:0]  pc;
      logic [127:0] pack;
      logic [3:0]   mask;
      logic         err;
   } exp_t;

   logic          clk = 1'b0;
   logic          resetn;
`ifdef ICACHE_FLUSH_EN
   logic          flush;
`endif
   logic          req_valid;
   logic          req_ready;
   logic [31:0]   req_pc;
   logic          resp_valid;
   logic [31:0]   resp_pc;
   logic [127:0]  resp_pack;
   logic [3:0]    resp_mask;
   logic          resp_err;
   logic [31:0]   araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic          arvalid;
   logic          arready;
   logic [31:0]   rdata;
   logic [1:0]    rresp;
   logic          rlast;
   logic          rvalid;
   logic          rready;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   int unsigned   cyc = 0;
   int unsigned   acc_cyc = 0;
   int unsigned   resp_cyc = 0;
   int unsigned   ar_cnt = 0;
   int unsigned   run = 0;
   int unsigned   max_run = 0;
   int            err_beat = -1;
   exp_t          exp_q[$];
   logic [31:0]   exp_ar[$];

   icache_2way_axi #(
      .SETS       (256),
      .LINE_WORDS (8),
      .FETCH_W    (4)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
`ifdef ICACHE_FLUSH_EN
      .flush      (flush),
`endif
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pc     (req_pc),
      .resp_valid (resp_valid),
      .resp_pc    (resp_pc),
      .resp_pack  (resp_pack),
      .resp_mask  (resp_mask),
      .resp_err   (resp_err),
      .araddr     (araddr),
      .arlen      (arlen),
      .arsize     (arsize),
      .arburst    (arburst),
      .arvalid    (arvalid),
      .arready    (arready),
      .rdata      (rdata),
      .rresp      (rresp),
      .rlast      (rlast),
      .rvalid     (rvalid),
      .rready     (rready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor / scoreboard.
   always @(negedge clk) begin
      if (resetn && resp_valid) begin
         run++;
         if (run > max_run) max_run = run;
         resp_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got pc %h with no response expected", resp_pc);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("resp", {resp_pc, resp_pack[95:0], resp_mask, resp_err},
                        {e.pc, e.pack[95:0], e.mask, e.err});
            chk("resp_word3", resp_pack[127:96], e.pack[127:96]);
         end
      end else begin
         run = 0;
      end
   end

   // AXI read slave.
   initial begin
      logic [31:0] line;
      arready = 1'b0;
      rvalid  = 1'b0;
      rlast   = 1'b0;
      rdata   = '0;
      rresp   = '0;
      forever begin
         @(negedge clk);
         if (resetn && arvalid) begin
            ar_cnt++;
            line = araddr;
            if (exp_ar.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ar: got araddr %h with no refill expected", araddr);
            end else begin
               chk("araddr", araddr, exp_ar.pop_front());
            end
            chk("ar_attr", {arlen, arsize, arburst}, {8'd7, 3'b010, 2'b01});
            arready = 1'b1;
            @(negedge clk);
            arready = 1'b0;
            chk("rready", rready, 1'b1);
            for (int k = 0; k < 8; k++) begin
               rvalid = 1'b1;
               rdata  = (line == 32'h1000) ? 32'hA0 + 32'(k) : 32'hC000_0000 + line + 32'(4 * k);
               rresp  = (k == err_beat) ? 2'b10 : 2'b00;
               rlast  = (k == 7);
               @(negedge clk);
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
         end
      end
   end

   task automatic send(input logic [31:0] pc);
      int unsigned n = 0;
      req_valid = 1'b1;
      req_pc    = pc;
      #1;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: req_ready %b for pc %h, required 1", req_ready, pc);
      end
      @(negedge clk);
      acc_cyc   = cyc;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int unsigned n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL resp_timeout: %0d responses outstanding, required 0", exp_q.size());
         exp_q.delete();
      end
      @(negedge clk);
   endtask

   task automatic access(input string name, input logic [31:0] pc, input logic [127:0] pack,
                         input logic [3:0] mask, input logic err, input bit miss);
      int unsigned a;
      exp_t e;
      a = ar_cnt;
      if (miss) exp_ar.push_back({pc[31:5], 5'b0});
      e.pc = pc; e.pack = pack; e.mask = mask; e.err = err;
      exp_q.push_back(e);
      send(pc);
      wait_drain();
      chk({name, "_latency"}, resp_cyc - acc_cyc, miss ? 10 : 0);
      chk({name, "_ar_count"}, ar_cnt - a, miss ? 1 : 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int unsigned a;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_pc    = '0;
`ifdef ICACHE_FLUSH_EN
      flush     = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_req_ready", req_ready, 1'b1);
      chk("reset_arvalid", arvalid, 1'b0);
      chk("reset_rready", rready, 1'b0);
      chk("reset_resp_valid", resp_valid, 1'b0);
      resetn = 1'b1;
      @(negedge clk);

      // Cold miss, then line-edge hit.
      access("cold_miss", 32'h1000, 128'h000000A3_000000A2_000000A1_000000A0, 4'b1111, 1'b0, 1'b1);
      access("line_edge", 32'h1018, 128'h00000000_00000000_000000A7_000000A6, 4'b0011, 1'b0, 1'b0);

      // Back-to-back hits with req_valid held.
      a = ar_cnt;
      max_run = 0;
      e.err = 1'b0; e.mask = 4'b1111;
      e.pc = 32'h1000; e.pack = 128'h000000A3_000000A2_000000A1_000000A0; exp_q.push_back(e);
      e.pc = 32'h1004; e.pack = 128'h000000A4_000000A3_000000A2_000000A1; exp_q.push_back(e);
      e.pc = 32'h1008; e.pack = 128'h000000A5_000000A4_000000A3_000000A2; exp_q.push_back(e);
      send(32'h1000);
      send(32'h1004);
      send(32'h1008);
      wait_drain();
      chk("b2b_run", max_run, 3);
      chk("b2b_ar_count", ar_cnt - a, 0);

      // LRU in set 0x80: T0=0x1000 resident, T1=0x3000, T2=0x5000.
      access("lru_fill_t1", 32'h3000, 128'hC000300C_C0003008_C0003004_C0003000, 4'b1111, 1'b0, 1'b1);
      access("lru_touch_t0", 32'h1000, 128'h000000A3_000000A2_000000A1_000000A0, 4'b1111, 1'b0, 1'b0);
      access("lru_fill_t2", 32'h5000, 128'hC000500C_C0005008_C0005004_C0005000, 4'b1111, 1'b0, 1'b1);
      access("lru_t0_hit", 32'h1004, 128'h000000A4_000000A3_000000A2_000000A1, 4'b1111, 1'b0, 1'b0);
      access("lru_t1_miss", 32'h3000, 128'hC000300C_C0003008_C0003004_C0003000, 4'b1111, 1'b0, 1'b1);

      // Refill error on the third beat, then the same PC misses again.
      err_beat = 2;
      access("refill_err", 32'h2040, 128'h0, 4'b0000, 1'b1, 1'b1);
      err_beat = -1;
      access("err_retry", 32'h2040, 128'hC000204C_C0002048_C0002044_C0002040, 4'b1111, 1'b0, 1'b1);
      access("err_retry_hit", 32'h2048, 128'hC0002054_C0002050_C000204C_C0002048, 4'b1111, 1'b0, 1'b0);

`ifdef ICACHE_FLUSH_EN
      begin
         int unsigned low = 0;
         flush = 1'b1;
         #1;
         while (!req_ready && low < 1000) begin
            low++;
            @(negedge clk);
            flush = 1'b0;
            #1;
         end
         flush = 1'b0;
         chk("flush_ready_low", low, 256);
         access("flush_miss", 32'h1000, 128'h000000A3_000000A2_000000A1_000000A0, 4'b1111, 1'b0, 1'b1);
      end
`endif

      repeat (3) @(negedge clk);
      chk("ar_queue_empty", exp_ar.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
